system_manager_cpu_mul_seq: RTL and testbench
=============================================

SYSTEM_MANAGER_CPU_MUL_SEQ -- requirements
Module: system_manager_cpu_mul_seq

Interface
REQ-001 SHALL have parameter HIGH_EN, default 1: 1 enables the high-word op; 0 forces every request to be treated as MUL.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: block can accept a request.
REQ-006 SHALL have port req_op_hi, input, 1: 0 = MUL (low 32 bits of product); 1 = MULXUU (high 32 bits, unsigned).
REQ-007 SHALL have ports req_a and req_b, input, 32 each: unsigned operands.
REQ-008 SHALL have port rsp_valid, output, 1: result present.
REQ-009 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port rsp_result, output, 32: result word.
REQ-011 SHALL have ports cell_src1 and cell_src2, output, 32 each, registered: operands driven to the multiplier cell.
REQ-012 SHALL have port cell_en, output, 1, registered: clock enable to the multiplier cell.
REQ-013 SHALL have ports cell_p1, cell_p2 and cell_p3, input, 32 each: partial products returned by the cell.
- p1 = src1[15:0]*src2[15:0]
- p2 = src1[15:0]*src2[31:16]
- p3 = src1[31:16]*src2[15:0]
- each product is valid on the cycle after the edge at which cell_en was sampled high.

Function
REQ-014 SHALL implement the states IDLE, ISSUE1, CAP1, ISSUE2, CAP2 and RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
- On acceptance: a, b and op_hi (op_hi ANDed with HIGH_EN) are latched, and the state moves to ISSUE1.
REQ-016 SHALL, on the edge entering ISSUE1, load cell_src1=a and cell_src2=b and set cell_en=1.
REQ-017 SHALL move from ISSUE1 to CAP1 unconditionally and clear cell_en on that edge.
REQ-018 SHALL handle CAP1 as follows, with the action taken on the edge leaving CAP1:
- MUL: register rsp_result = (p1 + ((p2 + p3) << 16)) mod 2^32 and go to RESP.
- MULXUU: store p1, p2 and p3 internally; load cell_src1={16'h0,a[31:16]} and cell_src2={16'h0,b[31:16]}; set cell_en=1; go to ISSUE2.
REQ-019 SHALL move from ISSUE2 to CAP2 unconditionally and clear cell_en on that edge.
REQ-020 SHALL, in CAP2, take p4 = cell_p1 and register rsp_result = bits [63:32] of the 64-bit sum S = P1 + (M << 16) + (p4 << 32), where P1 is the stored p1 and M = stored p2 + stored p3 is a 33-bit sum, then go to RESP.
- All carries into bit 32 SHALL be kept.
REQ-021 SHALL assert rsp_valid only in RESP, holding rsp_result stable until rsp_ready is high.
- On the edge where rsp_valid and rsp_ready are both high, the state returns to IDLE.
REQ-022 SHALL NOT overlap the response with a new acceptance; req_ready is 0 throughout RESP.
REQ-023 SHALL give the following latency, where k is the acceptance edge:
- MUL: rsp_valid rises after edge k+3.
- MULXUU: rsp_valid rises after edge k+5.
- Back-to-back throughput: one request per latency + 1 cycles.
REQ-024 SHALL keep cell_en at 0 in every state except ISSUE1 and ISSUE2.
REQ-025 SHALL hold cell_src1 and cell_src2 at their last loaded value outside the ISSUE states.
REQ-026 SHALL ignore req_valid, req_op_hi, req_a and req_b in every state other than IDLE.
REQ-027 SHALL treat cell_p* as don't-care outside CAP1 and CAP2.

Reset
REQ-028 SHALL, while reset_n=0, immediately force the following regardless of state:
- state = IDLE
- req_ready = 1
- rsp_valid = 0, rsp_result = 0
- cell_en = 0, cell_src1 = 0, cell_src2 = 0
- internal partial-product registers = 0
REQ-029 SHALL abort any in-flight operation when reset occurs mid-operation: no response is produced, and the first request after reset_n deasserts completes with a correct result and the nominal latency.

Verification
REQ-030 SHALL cover MUL 0x0001_0003 * 0x0002_0005 -> rsp_result = 0x000B_000F, with rsp_valid rising after edge k+3.
REQ-031 SHALL cover MULXUU 0xFFFF_FFFF * 0xFFFF_FFFF -> rsp_result = 0xFFFF_FFFE after edge k+5, and the same operands as MUL -> 0x0000_0001.
REQ-032 SHALL cover the carry path: MULXUU 0x0000_FFFF * 0xFFFF_FFFF -> 0x0000_FFFE; MULXUU 0x0001_0000 * 0x0001_0000 -> 0x0000_0001.
REQ-033 SHALL cover backpressure: rsp_ready held 0 for 3 cycles in RESP -> rsp_valid=1 and rsp_result stable, req_ready=0, cell_en=0 throughout; IDLE is reached on the edge where rsp_ready=1.
REQ-034 SHALL cover reset mid-operation: reset_n pulsed low during CAP1 of a MULXUU -> all outputs take reset values immediately; a following MUL 7*6 returns 0x0000_002A.
REQ-035 SHALL cover HIGH_EN=0: a MULXUU request with 0x0001_0003 * 0x0002_0005 returns the MUL result 0x000B_000F after edge k+3.

Source files
------------

// File: rtl/system_manager_cpu_mul_seq.sv
// Sequential 32x32 multiplier front-end. Drives an external 16x16 partial
// product cell: MUL needs one cell pass, MULXUU (unsigned high word) needs a
// second pass to form the high-half product a[31:16]*b[31:16].
module system_manager_cpu_mul_seq #(
    parameter int HIGH_EN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op_hi,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        CAP1   = 3'd2,
        ISSUE2 = 3'd3,
        CAP2   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_a_hi, r_b_hi;
    logic        r_hi;
    logic [31:0] r_p1, r_p2, r_p3;
    logic [31:0] r_src1, r_src2, r_result;
    logic        r_en;

    logic        w_hi_en;
    logic [31:0] w_lo;
    logic [32:0] w_m;
    logic [63:0] w_s;
    logic [31:0] w_hi;

    assign w_hi_en = (HIGH_EN != 0);

    // Low word: only the low 16 bits of (p2+p3) survive the shift, high half
    // of a*b never reaches the low word.
    assign w_lo = cell_p1 + ((cell_p2 + cell_p3) << 16);

    // High word: middle sum keeps its carry (33 bits), p4 comes from the
    // second cell pass, and every carry propagates into bit 32 and above.
    assign w_m  = {1'b0, r_p2} + {1'b0, r_p3};
    assign w_s  = {32'h0, r_p1} + ({31'h0, w_m} << 16) + {cell_p1, 32'h0};
    assign w_hi = 32'(w_s >> 32);

    assign cell_src1  = r_src1;
    assign cell_src2  = r_src2;
    assign cell_en    = r_en;
    assign rsp_result = r_result;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = ISSUE1;
            end
            ISSUE1: w_state_nxt = CAP1;
            CAP1:   w_state_nxt = r_hi ? ISSUE2 : RESP;
            ISSUE2: w_state_nxt = CAP2;
            CAP2:   w_state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, cell drive, partial-product capture and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_hi   <= '0;
            r_b_hi   <= '0;
            r_hi     <= 1'b0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_p3     <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_en     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a_hi <= req_a[31:16];
                        r_b_hi <= req_b[31:16];
                        r_hi   <= req_op_hi & w_hi_en;
                        r_src1 <= req_a;
                        r_src2 <= req_b;
                        r_en   <= 1'b1;
                    end
                end
                ISSUE1: r_en <= 1'b0;
                CAP1: begin
                    if (r_hi) begin
                        r_p1   <= cell_p1;
                        r_p2   <= cell_p2;
                        r_p3   <= cell_p3;
                        r_src1 <= {16'h0, r_a_hi};
                        r_src2 <= {16'h0, r_b_hi};
                        r_en   <= 1'b1;
                    end else begin
                        r_result <= w_lo;
                    end
                end
                ISSUE2: r_en <= 1'b0;
                CAP2:   r_result <= w_hi;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_system_manager_cpu_mul_seq.sv
// Directed bench: a behavioural 16x16 partial-product cell feeds each DUT.
// Latency k+3 / k+5 means rsp_valid is first seen high by the consumer at
// that edge, i.e. it is high when sampled after edge k+2 / k+4.
module tb_system_manager_cpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_op_hi, rsp_ready;
    logic [31:0] req_a, req_b;
    logic        req_ready, rsp_valid, cell_en;
    logic [31:0] rsp_result, cell_src1, cell_src2;
    logic [31:0] cell_p1, cell_p2, cell_p3;

    logic        l_req_valid, l_req_op_hi, l_rsp_ready;
    logic [31:0] l_req_a, l_req_b;
    logic        l_req_ready, l_rsp_valid, l_cell_en;
    logic [31:0] l_rsp_result, l_cell_src1, l_cell_src2;
    logic [31:0] l_cell_p1, l_cell_p2, l_cell_p3;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    system_manager_cpu_mul_seq #(.HIGH_EN(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op_hi(req_op_hi),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
        .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
    );

    system_manager_cpu_mul_seq #(.HIGH_EN(0)) u_dut_lo (
        .clk(clk), .reset_n(reset_n),
        .req_valid(l_req_valid), .req_ready(l_req_ready), .req_op_hi(l_req_op_hi),
        .req_a(l_req_a), .req_b(l_req_b),
        .rsp_valid(l_rsp_valid), .rsp_ready(l_rsp_ready), .rsp_result(l_rsp_result),
        .cell_src1(l_cell_src1), .cell_src2(l_cell_src2), .cell_en(l_cell_en),
        .cell_p1(l_cell_p1), .cell_p2(l_cell_p2), .cell_p3(l_cell_p3)
    );

    // Partial-product cells: one-cycle registered products, hold otherwise
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
        if (l_cell_en) begin
            l_cell_p1 <= {16'h0, l_cell_src1[15:0]}  * {16'h0, l_cell_src2[15:0]};
            l_cell_p2 <= {16'h0, l_cell_src1[15:0]}  * {16'h0, l_cell_src2[31:16]};
            l_cell_p3 <= {16'h0, l_cell_src1[31:16]} * {16'h0, l_cell_src2[15:0]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One transaction: lat = 3 (MUL) or 5 (MULXUU); hold = cycles of rsp_ready=0 in RESP
    task automatic run_op(input logic hi, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold,
                          input string tag);
        @(negedge clk);
        chk({tag, "_idle_rdy"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op_hi = hi; req_a = a; req_b = b;
        @(posedge clk);                                   // acceptance edge k
        #1;
        req_valid = 1'b0; req_op_hi = ~hi; req_a = 32'hA5A5_A5A5; req_b = 32'h5A5A_5A5A;
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);                               // after edge k+i
            chk({tag, "_busy_vld"}, {31'h0, rsp_valid}, 32'd0);
            chk({tag, "_busy_rdy"}, {31'h0, req_ready}, 32'd0);
            chk({tag, "_cell_en"}, {31'h0, cell_en},
                {31'h0, (i == 0) || (hi && i == 2)});
            @(posedge clk);
        end
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            chk({tag, "_rsp_vld"}, {31'h0, rsp_valid}, 32'd1);
            chk({tag, "_result"}, rsp_result, exp);
            chk({tag, "_rsp_rdy"}, {31'h0, req_ready}, 32'd0);
            chk({tag, "_rsp_en"}, {31'h0, cell_en}, 32'd0);
            if (i == hold) rsp_ready = 1'b1;
            @(posedge clk);
        end
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_vld"}, {31'h0, rsp_valid}, 32'd0);
        chk({tag, "_done_rdy"}, {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_op_hi = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        l_req_valid = 1'b0; l_req_op_hi = 1'b0; l_req_a = '0; l_req_b = '0; l_rsp_ready = 1'b1;
        #2;
        chk("rst_rdy",    {31'h0, req_ready}, 32'd1);
        chk("rst_vld",    {31'h0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_en",     {31'h0, cell_en}, 32'd0);
        chk("rst_src1",   cell_src1, 32'h0);
        chk("rst_src2",   cell_src2, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op(1'b0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 0, "mul_basic");
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0, "mulx_ones");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 0, "mul_ones");
        run_op(1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFE, 5, 0, "mulx_carry1");
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 5, 0, "mulx_carry2");
        run_op(1'b0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 3, "mul_bp");

        // Reset pulsed while a MULXUU sits in CAP1
        @(negedge clk);
        req_valid = 1'b1; req_op_hi = 1'b1; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
        @(posedge clk);                                   // k -> ISSUE1
        #1 req_valid = 1'b0;
        @(posedge clk);                                   // k+1 -> CAP1
        @(negedge clk);
        chk("mid_pre_rdy", {31'h0, req_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdy",    {31'h0, req_ready}, 32'd1);
        chk("mid_rst_vld",    {31'h0, rsp_valid}, 32'd0);
        chk("mid_rst_result", rsp_result, 32'h0);
        chk("mid_rst_en",     {31'h0, cell_en}, 32'd0);
        chk("mid_rst_src1",   cell_src1, 32'h0);
        chk("mid_rst_src2",   cell_src2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'h0, rsp_valid}, 32'd0);
        end
        run_op(1'b0, 32'd7, 32'd6, 32'h0000_002A, 3, 0, "mul_after_rst");

        // HIGH_EN=0 instance: MULXUU request behaves as MUL
        @(negedge clk);
        chk("lo_idle_rdy", {31'h0, l_req_ready}, 32'd1);
        l_req_valid = 1'b1; l_req_op_hi = 1'b1; l_req_a = 32'h0001_0003; l_req_b = 32'h0002_0005;
        @(posedge clk);                                   // acceptance edge k
        #1 l_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lo_busy_vld", {31'h0, l_rsp_valid}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);                                   // after edge k+2
        chk("lo_rsp_vld", {31'h0, l_rsp_valid}, 32'd1);
        chk("lo_result",  l_rsp_result, 32'h000B_000F);
        @(negedge clk);
        chk("lo_done_rdy", {31'h0, l_req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
